sys_array_feeder: RTL and testbench

//   Upstream feeder for the systolic array of sys_array_cell instances.
//   - Buffers one ARRAY_SIZE x ARRAY_SIZE weight matrix, then commits it with a one-cycle param_load.
//   - Streams input vectors as diagonal wavefronts: lane i is delayed i cycles.
//   - Appends a zero-filled drain phase so every partial sum leaves the array.

---
 rtl/sys_array_pkg.sv | 20 ++
 rtl/skew_delay_line.sv | 37 +++
 rtl/sys_array_feeder.sv | 198 +++++++++++++++++++
 tb/tb_sys_array_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array feeder.
package sys_array_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ARRAY_SIZE = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    STREAM,
    DRAIN
  } feeder_state_t;

  // Bit offset of a lane within a packed lane vector (lane 0 in LSBs).
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the input skew: DEPTH+1 registered stages, zero on reset or flush.
module skew_delay_line
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH+1];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH+1];

  // Shift one stage per cycle; flush forces every stage to zero.
  always_comb begin
    stage_d[0] = flush ? '0 : din;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      stage_d[k] = flush ? '0 : stage_q[k-1];
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH];

endmodule

// File: rtl/sys_array_feeder.sv
// Upstream feeder for the systolic array: buffers a weight matrix, commits it
// with a one-cycle param_load, streams skewed input wavefronts, then drains.
// Optional build macro: FEEDER_STALL_CNT_EN adds the stall_cnt output.
module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     w_valid,
  output logic                                     w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]         w_data,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic                                     s_last,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]         s_data,
  output logic                                     arr_param_load,
  output logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0] arr_param_data,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]         arr_input_data,
  output logic                                     busy,
  output logic                                     done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]                              stall_cnt
`endif
);

  localparam int unsigned LANE_W    = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned MAT_W     = ARRAY_SIZE * LANE_W;
  localparam int unsigned ROW_W     = $clog2(ARRAY_SIZE);
  // Drain occupies 2*ARRAY_SIZE-1 zero cycles plus the final done cycle.
  localparam int unsigned DRAIN_LEN = 2 * ARRAY_SIZE - 1;
  localparam int unsigned CNT_W     = $clog2(DRAIN_LEN + 1);

  feeder_state_t state_q, state_d;

  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MAT_W-1:0]  bank_q, bank_d;
  logic [MAT_W-1:0]  param_data_q, param_data_d;
  logic              param_load_q, param_load_d;
  logic              w_ready_q, w_ready_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              w_fire_c;
  logic              s_fire_c;
  logic              flush_c;
  logic [LANE_W-1:0] skew_in_c;

  // Next-state logic, weight bank capture and skew-line input selection.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    skew_in_c = '0;
    w_fire_c  = (state_q == LOAD) && w_valid && w_ready_q;
    s_fire_c  = (state_q == STREAM) && s_valid && s_ready_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          row_d   = '0;
        end
      end
      LOAD: begin
        if (w_fire_c) begin
          bank_d[row_q*LANE_W +: LANE_W] = w_data;
          if (row_q == ROW_W'(ARRAY_SIZE - 1)) begin
            state_d = COMMIT;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (s_fire_c) begin
          skew_in_c = s_data;
          if (s_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LEN)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    w_ready_d    = (state_d == LOAD);
    s_ready_d    = (state_d == STREAM);
    busy_d       = (state_d != IDLE);
    param_load_d = (state_d == COMMIT);
    param_data_d = param_data_q;
    done_d       = (state_q == DRAIN) && (cnt_q == CNT_W'(DRAIN_LEN - 1));
    if (state_d == COMMIT) begin
      param_data_d = bank_d;
    end
  end

  // The skew line is empty here anyway; flushing guarantees zero input during param_load.
  always_comb begin
    flush_c = (state_d == COMMIT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      bank_q       <= '0;
      param_data_q <= '0;
      param_load_q <= 1'b0;
      w_ready_q    <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      param_data_q <= param_data_d;
      param_load_q <= param_load_d;
      w_ready_q    <= w_ready_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Lane i is delayed i extra cycles to form the diagonal wavefront.
  for (genvar i = 0; i < int'(ARRAY_SIZE); i++) begin : g_lane
    skew_delay_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (i)
    ) u_skew (
      .clk  (clk),
      .reset(reset),
      .flush(flush_c),
      .din  (skew_in_c[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .dout (arr_input_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count STREAM cycles without a valid vector; saturating, cleared on accepted start.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q == STREAM) && !s_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign w_ready        = w_ready_q;
  assign s_ready        = s_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign arr_param_load = param_load_q;
  assign arr_param_data = param_data_q;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed, table-driven bench for sys_array_feeder (ARRAY_SIZE=4, DATA_WIDTH=8).
module tb_sys_array_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         w_valid = 1'b0;
  logic [31:0]  w_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [31:0]  s_data = '0;
  logic         w_ready, s_ready, arr_param_load, busy, done;
  logic [127:0] arr_param_data;
  logic [31:0]  arr_input_data;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  sys_array_feeder #(.DATA_WIDTH(8), .ARRAY_SIZE(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_last        (s_last),
    .s_data        (s_data),
    .arr_param_load(arr_param_load),
    .arr_param_data(arr_param_data),
    .arr_input_data(arr_input_data),
    .busy          (busy),
    .done          (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // flags = {busy, w_ready, s_ready, arr_param_load, done}
  localparam logic [4:0] F_IDLE   = 5'b00000;
  localparam logic [4:0] F_LOAD   = 5'b11000;
  localparam logic [4:0] F_COMMIT = 5'b10010;
  localparam logic [4:0] F_STREAM = 5'b10100;
  localparam logic [4:0] F_BUSY   = 5'b10000;
  localparam logic [4:0] F_DONE   = 5'b10001;

  localparam logic [31:0]  R0 = 32'h04030201;
  localparam logic [31:0]  R1 = 32'h08070605;
  localparam logic [31:0]  R2 = 32'h0C0B0A09;
  localparam logic [31:0]  R3 = 32'h100F0E0D;
  localparam logic [127:0] P1 = 128'h100F0E0D_0C0B0A09_08070605_04030201;

  typedef struct {
    logic         rst;
    logic         st;
    logic         wv;
    logic [31:0]  wd;
    logic         sv;
    logic         sl;
    logic [31:0]  sd;
    logic [4:0]   flags;
    logic [31:0]  ain;
    logic [127:0] pd;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst, input logic st, input logic wv, input logic [31:0] wd,
                     input logic sv, input logic sl, input logic [31:0] sd,
                     input logic [4:0] fl, input logic [31:0] ain, input logic [127:0] pd);
    vec_t v;
    v.rst = rst; v.st = st; v.wv = wv; v.wd = wd;
    v.sv = sv; v.sl = sl; v.sd = sd;
    v.flags = fl; v.ain = ain; v.pd = pd;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [164:0] act, input logic [164:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [164:0] snap();
    return {busy, w_ready, s_ready, arr_param_load, done, arr_input_data, arr_param_data};
  endfunction

  logic [31:0]  w2 [4];
  logic [127:0] p2;
  int           leak;

  initial begin
    // Job 1: reset, load with gaps, stream with a bubble, drain, done.
    for (int i = 0; i < 3; i++) add(1, 0, 0, '0, 0, 0, '0, F_IDLE, '0, '0);
    add(0, 0, 1, R3, 1, 1, 32'hDEADBEEF, F_IDLE, '0, '0);
    add(0, 1, 0, '0, 0, 0, '0, F_LOAD, '0, '0);
    add(0, 0, 1, R0, 0, 0, '0, F_LOAD, '0, '0);
    add(0, 1, 0, '0, 0, 0, '0, F_LOAD, '0, '0);
    add(0, 0, 1, R1, 0, 0, '0, F_LOAD, '0, '0);
    add(0, 0, 1, R2, 0, 0, '0, F_LOAD, '0, '0);
    add(0, 0, 0, '0, 0, 0, '0, F_LOAD, '0, '0);
    add(0, 0, 1, R3, 0, 0, '0, F_COMMIT, '0, P1);
    add(0, 0, 0, '0, 0, 0, '0, F_STREAM, '0, P1);
    add(0, 0, 0, '0, 1, 0, 32'h04030201, F_STREAM, 32'h00000001, P1);
    add(0, 0, 0, '0, 1, 0, 32'h08070605, F_STREAM, 32'h00000205, P1);
    add(0, 0, 0, '0, 0, 0, 32'h55555555, F_STREAM, 32'h00030600, P1);
    add(0, 0, 0, '0, 1, 0, 32'h0C0B0A09, F_STREAM, 32'h04070009, P1);
    add(0, 0, 0, '0, 1, 1, 32'h100F0E0D, F_BUSY, 32'h08000A0D, P1);
    add(0, 1, 1, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, F_BUSY, 32'h000B0E00, P1);
    add(0, 0, 0, '0, 0, 0, '0, F_BUSY, 32'h0C0F0000, P1);
    add(0, 0, 0, '0, 0, 0, '0, F_BUSY, 32'h10000000, P1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, '0, 0, 0, '0, F_BUSY, '0, P1);
    add(0, 0, 0, '0, 0, 0, '0, F_DONE, '0, P1);
    add(0, 1, 0, '0, 0, 0, '0, F_IDLE, '0, P1);
    add(0, 0, 0, '0, 0, 0, '0, F_IDLE, '0, P1);

    foreach (tbl[i]) begin
      reset   = tbl[i].rst;
      start   = tbl[i].st;
      w_valid = tbl[i].wv;
      w_data  = tbl[i].wd;
      s_valid = tbl[i].sv;
      s_last  = tbl[i].sl;
      s_data  = tbl[i].sd;
      step();
      chk($sformatf("vec%0d", i), snap(), {tbl[i].flags, tbl[i].ain, tbl[i].pd});
    end
    reset = 0; start = 0; w_valid = 0; s_valid = 0; s_last = 0; w_data = '0; s_data = '0;

    // Job 2: signed/extreme weights, then reset while data is still in the skew line.
    w2[0] = 32'h80FF7F01; w2[1] = 32'h00000000; w2[2] = 32'hFFFFFFFF; w2[3] = 32'h7F80017F;
    p2 = {w2[3], w2[2], w2[1], w2[0]};
    start = 1; step(); start = 0;
    chk("job2_load", 165'({busy, w_ready}), 165'(2'b11));
    for (int r = 0; r < 4; r++) begin
      w_valid = 1; w_data = w2[r]; step();
    end
    w_valid = 0;
    chk("job2_commit", snap(), {F_COMMIT, 32'h0, p2});
    step();
    chk("job2_stream", 165'(s_ready), 165'(1'b1));
    s_valid = 1; s_data = 32'h11223344; step(); s_valid = 0;
    chk("job2_lane0", 165'(arr_input_data), 165'(32'h00000044));
    step();
    chk("job2_lane1", 165'(arr_input_data), 165'(32'h00003300));
    reset = 1; step(); reset = 0;
    chk("mid_reset", snap(), 165'(0));
    leak = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done || busy || (arr_input_data != '0)) leak++;
    end
    chk("no_done_after_reset", 165'(leak), 165'(0));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_after_reset", 165'(stall_cnt), 165'(0));
`endif

    // Job 3: five bubbles, then a one-vector job with s_last on its first beat.
    start = 1; step(); start = 0;
    w_valid = 1;
    w_data = R0; step();
    w_data = R1; step();
    w_data = R2; step();
    w_data = R3; step();
    w_valid = 0;
    chk("job3_commit", snap(), {F_COMMIT, 32'h0, P1});
    step();
    for (int c = 0; c < 5; c++) step();
    chk("job3_still_stream", 165'({busy, s_ready}), 165'(2'b11));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_5", 165'(stall_cnt), 165'(5));
`endif
    s_valid = 1; s_last = 1; s_data = 32'hAABBCCDD; step(); s_valid = 0; s_last = 0;
    chk("last_t1", 165'({s_ready, busy, arr_input_data}), 165'({2'b01, 32'h000000DD}));
    step();
    chk("last_t2", 165'(arr_input_data), 165'(32'h0000CC00));
    step();
    chk("last_t3", 165'(arr_input_data), 165'(32'h00BB0000));
    step();
    chk("last_t4", 165'(arr_input_data), 165'(32'hAA000000));
    step(); step(); step();
    chk("last_t7", 165'({busy, done, arr_input_data}), 165'({2'b10, 32'h0}));
    step();
    chk("last_t8_done", 165'({busy, done}), 165'(2'b11));
    step();
    chk("last_t9_idle", 165'({busy, done}), 165'(2'b00));
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_held", 165'(stall_cnt), 165'(5));
    start = 1; step(); start = 0;
    chk("stall_cleared", 165'({busy, stall_cnt}), 165'({1'b1, 32'h0}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
